// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its buffer.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] BUBBLE_INSTR   = 32'h0000_0000;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: generic synchronous FIFO with flush; DEPTH must be a power of two.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: full blocks push unless a pop happens the same cycle; flush overrides push and pop.
module fetch_buf #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 2,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_dat,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: the head is only meaningful while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_dat;
    end

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch feeding decode through fetch_buf (FETCH_MISALIGN_CHECK_EN adds if_misalign).
// Latency: an instruction appears on if_valid the cycle after its imem_rvalid.
// Backpressure: id_ready low fills the buffer; no request issues unless a free slot is left for its response.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = FETCH_RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic        if_misalign,
`endif
    input  logic        id_ready
);

    localparam int CW = $clog2(BUF_DEPTH + 1);

    fetch_state_t  state;
    logic [31:0]   fetch_pc;
    logic          drop;
    logic          misalign_q;

    logic          buf_full;
    logic          buf_empty;
    logic [CW-1:0] buf_count;
    fetch_entry_t  push_ent;
    fetch_entry_t  head_ent;
    logic          push;
    logic          pop;
    logic          granted;

    logic [31:0]   redir_tgt;
    logic          redir_mis;
    logic          halt_nxt;
    logic          room_after_push;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign redir_tgt   = {redirect_pc[31:2], 2'b00};
    assign redir_mis   = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign if_misalign = misalign_q;
`else
    logic unused_redir_lsb;
    assign redir_tgt        = {redirect_pc[31:2], 2'b00};
    assign redir_mis        = 1'b0;
    assign unused_redir_lsb = ^redirect_pc[1:0];
`endif

    assign granted  = (state == REQ) && imem_gnt;
    assign pop      = !buf_empty && id_ready;
    assign push     = (state == WAIT) && imem_rvalid && !drop && !redirect_valid;
    // fetch_pc already moved past the granted word, so its PC is one word back.
    assign push_ent = '{instr: imem_rdata, pc: fetch_pc - 32'd4};

    assign halt_nxt        = redirect_valid ? redir_mis : misalign_q;
    assign room_after_push = pop || (buf_count < CW'(BUF_DEPTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            drop       <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            if (redirect_valid) begin
                fetch_pc   <= redir_tgt;
                misalign_q <= redir_mis;
            end else if (granted) begin
                fetch_pc   <= fetch_pc + 32'd4;
            end

            case (state)
                IDLE: begin
                    if (!halt_nxt && (redirect_valid || !buf_full || pop)) state <= REQ;
                end
                REQ: begin
                    if (imem_gnt) begin
                        state <= WAIT;
                        drop  <= redirect_valid;
                    end else if (halt_nxt) begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        drop <= 1'b0;
                        if (halt_nxt)
                            state <= IDLE;
                        else if (drop || redirect_valid || room_after_push)
                            state <= REQ;
                        else
                            state <= IDLE;
                    end else if (redirect_valid) begin
                        drop <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fetch_buf #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (push_ent),
        .pop      (pop),
        .flush    (redirect_valid),
        .full     (buf_full),
        .empty    (buf_empty),
        .head_dat (head_ent),
        .count    (buf_count)
    );

    assign imem_req  = (state == REQ);
    assign imem_addr = fetch_pc;
    assign if_valid  = !buf_empty;
    assign if_instr  = buf_empty ? BUBBLE_INSTR : head_ent.instr;
    assign if_pc     = buf_empty ? 32'h0 : head_ent.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder plus an in-order program-counter reference model.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
    localparam int          TB_DEPTH    = 2;
`ifdef FETCH_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        if_misalign;
`endif

    fetch_unit #(
        .RESET_PC  (TB_RESET_PC),
        .BUF_DEPTH (TB_DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
`ifdef FETCH_MISALIGN_CHECK_EN
        .if_misalign    (if_misalign),
`endif
        .id_ready       (id_ready)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    // Reference model: next PC decode must see, plus the single outstanding memory access.
    logic [31:0] exp_pc = TB_RESET_PC;
    bit          after_redir = 1'b0;
    bit          outst = 1'b0;
    logic [31:0] out_addr = 32'h0;
    int          cyc_left = 0;
    int          lat_lo = 1;
    int          lat_hi = 1;
    int          n_deliv = 0;
    logic [31:0] last_pc = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic compare();
        if (if_valid) begin
            check("if_pc", if_pc, exp_pc);
            check("if_instr", if_instr, mem_word(exp_pc));
        end else begin
            check("bubble_instr", if_instr, 32'h0);
            check("bubble_pc", if_pc, 32'h0);
        end
        if (after_redir) check1("valid_after_redirect", if_valid, 1'b0);
        check1("single_outstanding", imem_req && outst, 1'b0);
        check("addr_align", {30'h0, imem_addr[1:0]}, 32'h0);
    endtask

    // One clock: drive inputs, compare outputs, then advance the model past the edge.
    task automatic step(input bit gnt, input bit rdy, input bit redir, input logic [31:0] rpc);
        bit          granted;
        bit          deliv;
        logic [31:0] gaddr;
        logic [31:0] dpc;
        imem_gnt       = gnt;
        id_ready       = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_rvalid    = outst && (cyc_left <= 1);
        imem_rdata     = imem_rvalid ? mem_word(out_addr) : 32'hDEAD_BEEF;
        compare();
        granted = imem_req && gnt;
        gaddr   = imem_addr;
        deliv   = if_valid && rdy && !redir;
        dpc     = if_pc;
        @(posedge clk);
        #1;
        cycle++;
        if (imem_rvalid) outst = 1'b0;
        else if (outst) cyc_left--;
        if (granted) begin
            outst    = 1'b1;
            out_addr = gaddr;
            cyc_left = $urandom_range(lat_hi, lat_lo);
        end
        if (deliv) begin
            last_pc = dpc;
            n_deliv++;
            exp_pc  = exp_pc + 32'd4;
        end
        if (redir) exp_pc = {rpc[31:2], 2'b00};
        after_redir = redir;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check1("rst_imem_req", imem_req, 1'b0);
        check("rst_imem_addr", imem_addr, TB_RESET_PC);
        check1("rst_if_valid", if_valid, 1'b0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
        check1("rst_if_misalign", if_misalign, 1'b0);
`endif
        outst       = 1'b0;
        exp_pc      = TB_RESET_PC;
        after_redir = 1'b0;
        rst_n       = 1'b1;
        @(posedge clk);
        #1;
        cycle++;
        check1("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, TB_RESET_PC);
    endtask

    task automatic run_deliv(input int n, input string name);
        int target;
        target = n_deliv + n;
        for (int i = 0; i < 200 && n_deliv < target; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
        check1({name, "_progress"}, n_deliv >= target, 1'b1);
    endtask

    int          t_seq [4];
    logic [31:0] p_seq [4];
    int          k;
    int          base;
    bit          found;
    bit          r_redir;
    bit          r_gnt;
    bit          r_rdy;
    logic [31:0] r_tgt;

    initial begin
        do_reset();

        // Back-to-back streaming: one instruction every two cycles from RESET_PC upward.
        lat_lo = 1;
        lat_hi = 1;
        k = 0;
        for (int i = 0; i < 12; i++) begin
            if (if_valid && k < 4) begin
                t_seq[k] = i;
                p_seq[k] = if_pc;
                k++;
            end
            step(1'b1, 1'b1, 1'b0, 32'h0);
        end
        check("seq_count", 32'(k), 32'd4);
        for (int i = 0; i < 4; i++) check("seq_pc", p_seq[i], TB_RESET_PC + 32'(i * 4));
        for (int i = 0; i < 3; i++) check("seq_spacing", 32'(t_seq[i+1] - t_seq[i]), 32'd2);

        // Decode stall: buffer fills, requests stop, exactly BUF_DEPTH entries drain.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        check1("stall_req_low", imem_req, 1'b0);
        check1("stall_valid", if_valid, 1'b1);
        base = n_deliv;
        for (int i = 0; i < TB_DEPTH + 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
        check("stall_drained", 32'(n_deliv - base), 32'(TB_DEPTH));

        // Redirect while requesting without grant replaces the address, request stays up.
        step(1'b0, 1'b1, 1'b1, 32'h40);
        check1("redir_req_held", imem_req, 1'b1);
        check("redir_req_addr", imem_addr, 32'h40);
        run_deliv(1, "redir_req");
        check("redir_req_pc", last_pc, 32'h40);

        // Reset while an access is outstanding.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (outst) found = 1'b1;
            else step(1'b1, 1'b1, 1'b0, 32'h0);
        end
        check1("mid_reset_outst", found, 1'b1);
        do_reset();

        // Redirect while waiting on the response for pc 8.
        lat_lo = 3;
        lat_hi = 3;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (imem_req && imem_addr == 32'h8) found = 1'b1;
            step(1'b1, 1'b1, 1'b0, 32'h0);
        end
        check1("wait_on_8", found, 1'b1);
        step(1'b0, 1'b1, 1'b1, 32'h100);
        run_deliv(1, "redir_wait");
        check("redir_wait_pc", last_pc, 32'h100);

        // Redirect coincident with rvalid.
        lat_lo = 2;
        lat_hi = 2;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (outst && cyc_left <= 1) found = 1'b1;
            else step(1'b1, 1'b1, 1'b0, 32'h0);
        end
        check1("rvalid_setup", found, 1'b1);
        step(1'b1, 1'b1, 1'b1, 32'h200);
        run_deliv(1, "redir_rvalid");
        check("redir_rvalid_pc", last_pc, 32'h200);

        // Redirect coincident with a pop.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (if_valid) found = 1'b1;
            else step(1'b1, 1'b0, 1'b0, 32'h0);
        end
        check1("pop_setup", found, 1'b1);
        step(1'b1, 1'b1, 1'b1, 32'h300);
        run_deliv(1, "redir_pop");
        check("redir_pop_pc", last_pc, 32'h300);

        // Back-to-back redirects: the last target wins.
        step(1'b1, 1'b1, 1'b1, 32'h400);
        step(1'b1, 1'b1, 1'b1, 32'h500);
        run_deliv(1, "redir_b2b");
        check("redir_b2b_pc", last_pc, 32'h500);

        // 32-bit wrap of the fetch address.
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        run_deliv(3, "wrap");
        check("wrap_pc", last_pc, 32'h0);

`ifdef FETCH_MISALIGN_CHECK_EN
        step(1'b1, 1'b1, 1'b1, 32'h102);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
        check1("mis_flag", if_misalign, 1'b1);
        check1("mis_req", imem_req, 1'b0);
        check1("mis_valid", if_valid, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h200);
        check1("mis_clear", if_misalign, 1'b0);
        run_deliv(1, "mis_resume");
        check("mis_resume_pc", last_pc, 32'h200);
`else
        step(1'b1, 1'b1, 1'b1, 32'h603);
        run_deliv(1, "redir_lsb");
        check("redir_lsb_pc", last_pc, 32'h600);
`endif

        // Random grant/response timing, stalls and redirects against the PC model.
        lat_lo = 1;
        lat_hi = 6;
        base = n_deliv;
        for (int i = 0; i < 4000; i++) begin
            r_redir = ($urandom_range(99, 0) < 3);
            r_gnt   = ($urandom_range(1, 0) == 1);
            r_rdy   = ($urandom_range(3, 0) != 0);
            r_tgt   = $urandom;
            if ($urandom_range(3, 0) == 0) r_tgt = 32'hFFFF_FFE0 | (r_tgt & 32'h1F);
            if (MIS_EN) r_tgt[1:0] = 2'b00;
            step(r_gnt, r_rdy, r_redir, r_tgt);
        end
        check1("random_progress", (n_deliv - base) >= 200, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2: instruction buffer entries; legal values are 2 and 4.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 imem_req  out  1  fetch request valid.
REQ-006 imem_addr  out  32  fetch address; word-aligned.
REQ-007 imem_gnt  in  1  request accepted in the cycle where imem_req && imem_gnt.
REQ-008 imem_rvalid  in  1  response valid; arrives at least 1 cycle after its grant, in order.
REQ-009 imem_rdata  in  32  fetched instruction word.
REQ-010 redirect_valid  in  1  PC redirect from a taken branch or jump (NextPC != pc+4).
REQ-011 redirect_pc  in  32  redirect target.
REQ-012 if_valid  out  1  if_instr/if_pc hold a valid instruction for the decode stage.
REQ-013 if_instr  out  32  instruction to decode; 32'h0 whenever if_valid=0.
REQ-014 if_pc  out  32  PC of if_instr; 32'h0 whenever if_valid=0.
REQ-015 id_ready  in  1  decode stage consumes the head in the cycle where if_valid && id_ready.
REQ-016 if_misalign  out  1  redirect target not 4-aligned; present only with FETCH_MISALIGN_CHECK_EN.

Function
REQ-017 At most one request is outstanding (granted, no response yet).
REQ-018 The FSM has three states: IDLE (no request and none outstanding), REQ (imem_req=1), WAIT (granted, awaiting imem_rvalid).
REQ-019 IDLE->REQ when free buffer slots exceed the in-flight count; REQ->WAIT on grant; WAIT->REQ on rvalid when a slot remains after the write; WAIT->IDLE on rvalid otherwise.
REQ-020 fetch_pc advances by 4 on each grant; 32-bit wrap-around from 32'hFFFF_FFFC to 0 is legal.
REQ-021 A non-dropped response writes {imem_rdata, pc} into the buffer on the rvalid cycle; if_valid rises the following cycle, giving 1-cycle buffer latency.
REQ-022 Pop and push in the same cycle are both performed when the buffer is full; buffer overflow is impossible by construction.
REQ-023 On redirect_valid: the buffer is flushed, fetch_pc<=redirect_pc, and if_valid=0 next cycle; an outstanding response is marked drop and discarded on arrival.
REQ-024 In REQ without grant, a redirect replaces imem_addr next cycle; imem_req stays high.
REQ-025 Redirect in the same cycle as a grant: the granted response is dropped and a new request to redirect_pc issues after it returns.
REQ-026 Redirect in the same cycle as a pop: the flush wins; the pop is not reported again.
REQ-027 Redirect in the same cycle as rvalid: the response is discarded.
REQ-028 Back-to-back redirects: the last one wins.
REQ-029 When the buffer is empty, if_instr=32'h0, so the decoder sees opcode ZERO as a bubble.

Reset
REQ-030 While rst_n=0: state=IDLE, fetch_pc=RESET_PC, buffer empty, drop flag=0, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_misalign=0.
REQ-031 The first imem_req rises in the first cycle after rst_n deasserts.
REQ-032 Reset asserted mid-transaction abandons the outstanding response; the memory side is reset concurrently.

Configuration
REQ-033 With FETCH_MISALIGN_CHECK_EN defined: a redirect with redirect_pc[1:0]!=0 sets if_misalign (sticky until reset or the next aligned redirect), halts fetching, and keeps if_valid=0.
REQ-034 Without FETCH_MISALIGN_CHECK_EN: the port is absent and redirect_pc[1:0] is forced to 0.

Structure
REQ-035 The shared package holds the fetch_state_t enum (IDLE/REQ/WAIT), the BUBBLE_INSTR=32'h0 constant, and the RESET_PC default.
REQ-036 The buffer is the sub-module fetch_buf: a parameterized synchronous FIFO with push, pop, flush, full and empty.

Verification
REQ-037 Reset release, gnt=1, rvalid 1 cycle later, id_ready=1 -> if_pc sequence 0,4,8,...; one if_valid every 2 cycles.
REQ-038 id_ready=0 for 10 cycles -> the buffer fills to BUF_DEPTH, imem_req drops, and no instruction is lost or duplicated after release.
REQ-039 Redirect to 32'h100 while WAIT on pc 8 -> the response for 8 is dropped, the next if_pc=32'h100, and no stale if_valid appears.
REQ-040 Redirect coincident with rvalid and with pop -> neither instruction is delivered; next if_pc=redirect_pc.
REQ-041 Random gnt/rvalid delays of 0-5 cycles against a reference PC model -> exact in-order match.
REQ-042 With FETCH_MISALIGN_CHECK_EN, redirect to 32'h102 -> if_misalign=1, imem_req=0, if_valid=0; a following redirect to 32'h200 clears it and resumes fetch.
